// File: rtl/timer_pkg.sv
// Shared register map and per-channel types for the MMIO timer bank.
package timer_pkg;
    localparam logic [3:0]  OFF_RELOAD  = 4'h0;
    localparam logic [3:0]  OFF_COUNT   = 4'h4;
    localparam logic [3:0]  OFF_CTRL    = 4'h8;
    localparam logic [3:0]  OFF_STATUS  = 4'hC;
    localparam logic [31:0] CH_STRIDE   = 32'h10;
    localparam logic [31:0] IRQ_SUM_OFF = 32'h80;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_ONESHOT   = 2;
    localparam int CTRL_PRESC_LSB = 16;

    typedef struct packed {
        logic reload;
        logic count;
        logic ctrl;
        logic status;
    } chan_wr_t;

    // presc is carried zero-extended to 16 bits whatever PRESC_W is
    typedef struct packed {
        logic [31:0] reload;
        logic [31:0] count;
        logic [15:0] presc;
        logic        oneshot;
        logic        irq_en;
        logic        enable;
        logic        pending;
    } chan_regs_t;

    function automatic logic [31:0] ctrl_word(input chan_regs_t r);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN]      = r.enable;
        w[CTRL_IRQ_EN]  = r.irq_en;
        w[CTRL_ONESHOT] = r.oneshot;
        w[31:16]        = r.presc;
        return w;
    endfunction
endpackage

// File: rtl/timer_channel.sv
// One timer channel: RELOAD/COUNT/CTRL/STATUS registers, prescaler and overflow.
module timer_channel
    import timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  chan_wr_t    we,
    input  logic [31:0] wdata,
    output chan_regs_t  regs
);
    logic [31:0]        reload;
    logic [31:0]        count;
    logic               enable;
    logic               irq_en;
    logic               oneshot;
    logic               pending;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] psc;
    logic               tick;
    logic               ovf;

    assign tick = enable && (psc == presc);
    assign ovf  = tick && (count == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload  <= '0;
            count   <= '0;
            enable  <= 1'b0;
            irq_en  <= 1'b0;
            oneshot <= 1'b0;
            presc   <= '0;
            psc     <= '0;
            pending <= 1'b0;
        end else begin
            if (we.reload)
                reload <= wdata;

            // CPU write beats the tick for the register it targets
            if (we.count)
                count <= wdata;
            else if (ovf)
                count <= reload;
            else if (tick)
                count <= count + 32'd1;

            if (we.ctrl) begin
                enable  <= wdata[CTRL_EN];
                irq_en  <= wdata[CTRL_IRQ_EN];
                oneshot <= wdata[CTRL_ONESHOT];
                presc   <= wdata[CTRL_PRESC_LSB +: PRESC_W];
                psc     <= '0;
            end else begin
                if (ovf && oneshot)
                    enable <= 1'b0;
                if (enable)
                    psc <= tick ? '0 : psc + 1'b1;
            end

            // overflow set has priority over write-1-clear
            if (ovf)
                pending <= 1'b1;
            else if (we.status && wdata[0])
                pending <= 1'b0;
        end
    end

    always_comb begin
        regs         = '0;
        regs.reload  = reload;
        regs.count   = count;
        regs.presc   = 16'(presc);
        regs.oneshot = oneshot;
        regs.irq_en  = irq_en;
        regs.enable  = enable;
        regs.pending = pending;
    end
endmodule

// File: rtl/mmio_timer_bank.sv
// Bank of N_TIMERS memory-mapped timers: address decode, read mux, interrupt fan-in.
module mmio_timer_bank
    import timer_pkg::*;
#(
    parameter int          N_TIMERS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100,
    parameter int          PRESC_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [N_TIMERS-1:0] irq_vec,
    output logic                irqout
);
    logic [31:0]         off;
    logic                ch_hit;
    logic                sum_hit;
    logic [2:0]          idx;
    logic [3:0]          reg_off;
    logic [N_TIMERS-1:0] pend;
    chan_regs_t          regs [N_TIMERS];

    // addresses below BASE_ADDR wrap to a huge offset and miss every window
    assign off     = addr - BASE_ADDR;
    assign ch_hit  = (off < 32'(N_TIMERS) * CH_STRIDE) && (off[1:0] == 2'b00);
    assign sum_hit = (off == IRQ_SUM_OFF);
    assign idx     = off[6:4];
    assign reg_off = off[3:0];

    for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
        chan_wr_t we;
        logic     sel;

        assign sel       = wr && ch_hit && (idx == 3'(k));
        assign we.reload = sel && (reg_off == OFF_RELOAD);
        assign we.count  = sel && (reg_off == OFF_COUNT);
        assign we.ctrl   = sel && (reg_off == OFF_CTRL);
        assign we.status = sel && (reg_off == OFF_STATUS);

        timer_channel #(.PRESC_W(PRESC_W)) u_ch (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .wdata (wdata),
            .regs  (regs[k])
        );

        assign pend[k]    = regs[k].pending;
        assign irq_vec[k] = regs[k].pending & regs[k].irq_en;
    end

    assign irqout = |irq_vec;

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sum_hit) begin
                rdata = 32'(pend);
            end else if (ch_hit) begin
                for (int k = 0; k < N_TIMERS; k++) begin
                    if (idx == 3'(k)) begin
                        case (reg_off)
                            OFF_RELOAD: rdata = regs[k].reload;
                            OFF_COUNT:  rdata = regs[k].count;
                            OFF_CTRL:   rdata = ctrl_word(regs[k]);
                            OFF_STATUS: rdata = {31'b0, regs[k].pending};
                            default:    rdata = '0;
                        endcase
                    end
                end
            end
        end
    end
endmodule
